// File: rtl/mmio_pkg.sv
// Shared definitions for the CPU memory-mapped I/O path: the I/O address map,
// the UART status/data select encodings and the read-source encodings.
package mmio_pkg;

  localparam logic [31:0] ADDR_UART_TX_READY = 32'h8000_0000;
  localparam logic [31:0] ADDR_UART_RX_VALID = 32'h8000_0004;
  localparam logic [31:0] ADDR_UART_TX_DATA  = 32'h8000_0008;
  localparam logic [31:0] ADDR_UART_RX_DATA  = 32'h8000_000C;
  localparam logic [31:0] ADDR_CYCLE_COUNT   = 32'h8000_0010;
  localparam logic [31:0] ADDR_INSTR_COUNT   = 32'h8000_0014;
  localparam logic [31:0] ADDR_COUNT_RESET   = 32'h8000_0018;

  typedef enum logic [1:0] {
    SEL_DATAOUT    = 2'b00,
    SEL_DIN_READY  = 2'b01,
    SEL_DOUT_VALID = 2'b10,
    SEL_RESERVED   = 2'b11
  } uart_sel_e;

  typedef enum logic {
    RD_SRC_UART    = 1'b0,
    RD_SRC_COUNTER = 1'b1
  } rd_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer MSB to tell full from empty.
// Pushes into a full FIFO and pops from an empty one are ignored; full and
// empty come only from registered pointers, so head/full/empty never depend
// combinationally on this cycle's push or pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; reset discards everything queued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/mmio_uart_responder.sv
// Responder for the CPU memory-mapped I/O window 0x80000000-0x80000018.
// Buffers UART TX/RX bytes, keeps the cycle and instruction counters and
// returns a registered read result one cycle after the request.
// Optional sticky error flags are built when UART_ERR_FLAGS_EN is defined.
module mmio_uart_responder
  import mmio_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_uart,
  input  logic        re_uart,
  input  logic [1:0]  uart_sel,
  input  logic        rd_src,
  input  logic        ct_sel,
  input  logic        ct_reset,
  input  logic        instr_retire,
  input  logic [31:0] wr_data,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             tx_full;
  logic             tx_empty;
  logic             rx_full;
  logic             rx_empty;
  logic [7:0]       rx_head;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic [31:0]      status_base;
  logic [31:0]      read_next;
  logic [23:0]      wr_data_unused;

  assign wr_data_unused = wr_data[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (we_uart),
    .push_data (wr_data[7:0]),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (re_uart),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

`ifdef UART_ERR_FLAGS_EN
  logic tx_overflow;
  logic rx_underflow;

  // Sticky error flags; a counter reset clears them even if an error occurs that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else if (ct_reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (we_uart && tx_full) begin
        tx_overflow <= 1'b1;
      end
      if (re_uart && rx_empty) begin
        rx_underflow <= 1'b1;
      end
    end
  end

  assign status_base = {22'h0, rx_underflow, tx_overflow, 8'h00};
`else
  assign status_base = 32'h0;
`endif

  // Free-running cycle counter and retired-instruction counter, cleared by ct_reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (ct_reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_ONE;
      if (instr_retire) begin
        instr_count <= instr_count + CNT_ONE;
      end
    end
  end

  // Read mux evaluated on pre-edge state so a popping DataOut read returns the popped byte
  always_comb begin
    read_next = 32'h0;
    if (rd_src == RD_SRC_COUNTER) begin
      read_next = ct_sel ? 32'(instr_count) : 32'(cycle_count);
    end else begin
      case (uart_sel)
        SEL_DATAOUT:    read_next = rx_empty ? 32'h0 : {24'h0, rx_head};
        SEL_DIN_READY:  read_next = status_base | {31'h0, !tx_full};
        SEL_DOUT_VALID: read_next = status_base | {31'h0, !rx_empty};
        default:        read_next = 32'h0;
      endcase
    end
  end

  // Register the read result for the writeback mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= 32'h0;
    end else begin
      read_data <= read_next;
    end
  end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Self-checking bench for mmio_uart_responder: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
// Define UART_ERR_FLAGS_EN for both bench and RTL to cover the error flags.
module tb_mmio_uart_responder;

  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam int CNT_W    = 8;
  localparam int CNT_MASK = (1 << CNT_W) - 1;

  logic        clk;
  logic        reset;
  logic        we_uart;
  logic        re_uart;
  logic [1:0]  uart_sel;
  logic        rd_src;
  logic        ct_sel;
  logic        ct_reset;
  logic        instr_retire;
  logic [31:0] wr_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  int         cyc;
  int         ins;
  logic       tx_ovf;
  logic       rx_unf;

  mmio_uart_responder #(
    .TX_DEPTH (TX_DEPTH),
    .RX_DEPTH (RX_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .we_uart      (we_uart),
    .re_uart      (re_uart),
    .uart_sel     (uart_sel),
    .rd_src       (rd_src),
    .ct_sel       (ct_sel),
    .ct_reset     (ct_reset),
    .instr_retire (instr_retire),
    .wr_data      (wr_data),
    .read_data    (read_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    cyc    = 0;
    ins    = 0;
    tx_ovf = 1'b0;
    rx_unf = 1'b0;
  endtask

  // Drive one cycle of inputs, check state-derived outputs, advance the model, check the read
  task automatic apply_stimulus(input logic we, input logic re, input logic [1:0] sel,
                                input logic src, input logic cs, input logic ctr,
                                input logic ir, input logic [7:0] wd, input logic tr,
                                input logic rv, input logic [7:0] rd_in);
    logic [31:0] exp_rd;
    logic [31:0] flag_bits;
    int          tx_n;
    int          rx_n;
    we_uart      = we;
    re_uart      = re;
    uart_sel     = sel;
    rd_src       = src;
    ct_sel       = cs;
    ct_reset     = ctr;
    instr_retire = ir;
    wr_data      = $urandom();
    wr_data[7:0] = wd;
    tx_ready     = tr;
    rx_valid     = rv;
    rx_data      = rd_in;
    #1;
    tx_n = tx_q.size();
    rx_n = rx_q.size();
    check_output("tx_valid", 32'(tx_valid), 32'(tx_n != 0));
    if (tx_n != 0) begin
      check_output("tx_data", 32'(tx_data), 32'(tx_q[0]));
    end
    check_output("rx_ready", 32'(rx_ready), 32'(rx_n < RX_DEPTH));

`ifdef UART_ERR_FLAGS_EN
    flag_bits = {22'h0, rx_unf, tx_ovf, 8'h00};
`else
    flag_bits = 32'h0;
`endif
    if (src) begin
      exp_rd = cs ? 32'(ins) : 32'(cyc);
    end else if (sel == 2'b00) begin
      exp_rd = (rx_n != 0) ? 32'(rx_q[0]) : 32'h0;
    end else if (sel == 2'b01) begin
      exp_rd = flag_bits | 32'(tx_n < TX_DEPTH);
    end else if (sel == 2'b10) begin
      exp_rd = flag_bits | 32'(rx_n != 0);
    end else begin
      exp_rd = 32'h0;
    end

    if (tx_n != 0 && tr) void'(tx_q.pop_front());
    if (we) begin
      if (tx_n < TX_DEPTH) tx_q.push_back(wd);
      else tx_ovf = 1'b1;
    end
    if (re) begin
      if (rx_n != 0) void'(rx_q.pop_front());
      else rx_unf = 1'b1;
    end
    if (rv && rx_n < RX_DEPTH) rx_q.push_back(rd_in);
    if (ctr) begin
      cyc    = 0;
      ins    = 0;
      tx_ovf = 1'b0;
      rx_unf = 1'b0;
    end else begin
      cyc = (cyc + 1) & CNT_MASK;
      if (ir) ins = (ins + 1) & CNT_MASK;
    end

    @(posedge clk);
    #1;
    check_output("read_data", read_data, exp_rd);
  endtask

  task automatic idle_read(input logic cs);
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1, cs, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] tx_bytes [5];
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    we_uart      = 1'b0;
    re_uart      = 1'b0;
    uart_sel     = 2'b00;
    rd_src       = 1'b0;
    ct_sel       = 1'b0;
    ct_reset     = 1'b0;
    instr_retire = 1'b0;
    wr_data      = 32'h0;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_read_data", read_data, 32'h0);
    reset = 1'b0;

    // Idle after reset: cycle count grows, instruction count stays 0
    repeat (5) idle_read(1'b0);
    idle_read(1'b1);

    // TX fill with the core stalled, one dropped push, then drain in order
    tx_bytes[0] = 8'h41; tx_bytes[1] = 8'h42; tx_bytes[2] = 8'h43;
    tx_bytes[3] = 8'h44; tx_bytes[4] = 8'h45;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, tx_bytes[i], 1'b0, 1'b0, 8'h00);
    end
    apply_stimulus(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    repeat (5) apply_stimulus(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // RX delivery, two popping reads, then a pop on empty
    apply_stimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
    apply_stimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5);
    apply_stimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    repeat (3) apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Flags cleared by ct_reset
    apply_stimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // RX fill to full, pop one, then simultaneous push and pop at three entries
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h10 + i));
    end
    apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77);
    check_output("rx_count_after_simul", 32'(rx_q.size()), 32'd3);
    repeat (4) apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Instruction counter then a counter reset read in the same cycle
    repeat (7) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    idle_read(1'b1);
    idle_read(1'b0);

    // Long idle stretch so the cycle counter wraps
    repeat (300) idle_read(1'b0);

    // Reset mid-transfer: TX holds data, reset must drop tx_valid immediately
    repeat (2) apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, 8'h66);
    reset = 1'b1;
    #1;
    check_output("midreset_tx_valid", 32'(tx_valid), 32'h0);
    check_output("midreset_rx_ready", 32'(rx_ready), 32'h1);
    check_output("midreset_read_data", read_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0),
                     1'($urandom_range(0, 1)), 8'($urandom()),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                     8'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmio_uart_responder.md
Name: mmio_uart_responder

Overview:
- Responder side of the CPU memory-mapped I/O path: executes the UART and counter strobes the control unit issues for 0x80000000–0x80000018.
- Buffers TX/RX bytes in small FIFOs between the CPU and the serial UART core (ready/valid on both sides).
- Maintains the cycle and instruction counters; returns registered read data to the writeback mux.

Parameters:
- TX_DEPTH, 4, TX FIFO entries (power of two, ≥2)
- RX_DEPTH, 4, RX FIFO entries (power of two, ≥2)
- CNT_W, 32, counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- we_uart  in  1  store to 0x80000008: push wr_data[7:0] into TX FIFO
- re_uart  in  1  load from 0x8000000c: pop RX FIFO head
- uart_sel  in  2  status/data select: 00 DataOut, 01 DataInReady, 10 DataOutValid, 11 reserved
- rd_src  in  1  read source: 0 UART, 1 counter
- ct_sel  in  1  counter select: 0 cycle (0x80000010), 1 instruction (0x80000014)
- ct_reset  in  1  store to 0x80000018: clear both counters
- instr_retire  in  1  one instruction retired this cycle
- wr_data  in  32  store data; only [7:0] used
- read_data  out  32  registered read result
- tx_data  out  8  TX FIFO head to UART core
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART core accepts tx_data
- rx_data  in  8  byte from UART core
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  RX FIFO not full

Behaviour:
- Reset (async, active-high): both FIFOs empty, pointers 0, counters 0, read_data 0, tx_valid 0, rx_ready 1 on the first cycle after deassert.
- TX push: on we_uart && !tx_full, wr_data[7:0] is written at the tail.
- TX full is evaluated before any same-cycle pop. A push to a full FIFO is dropped, even if a core pop occurs that cycle.
- TX pop: on tx_valid && tx_ready. tx_data and tx_valid come from registered FIFO state; there is no combinational path from we_uart.
- RX push: on rx_valid && rx_ready; rx_ready = !rx_full, registered-state-derived.
- RX pop: on re_uart && !rx_empty. re_uart on empty is a no-op.
- RX simultaneous push and pop on a non-empty FIFO: both occur and the count is unchanged.
- Push and pop on empty: push only.
- Pointers wrap modulo depth. Full/empty use an extra pointer MSB.
- read_data is updated every cycle, reflecting the pre-edge state:
  - rd_src=0, uart_sel=00: {24'b0, RX head}, or 0 if RX is empty.
  - rd_src=0, uart_sel=01: {31'b0, !tx_full}.
  - rd_src=0, uart_sel=10: {31'b0, !rx_empty}.
  - rd_src=0, uart_sel=11: 0.
  - rd_src=1: ct_sel ? instr_count : cycle_count.
- Read latency is exactly 1 cycle. A DataOut read with re_uart returns the byte being popped, not the next one.
- cycle_count increments every cycle. instr_count increments when instr_retire is high.
- Both counters wrap from 2^CNT_W−1 to 0.
- ct_reset: both counters are 0 after the edge; that cycle's increment is suppressed. ct_reset has priority over increment.
- Counter values read in the same cycle as ct_reset are the pre-clear values.
- Reset mid-transfer: FIFO contents are discarded and no partial byte is presented. tx_valid drops asynchronously with reset.

Optional Feature:
- Macro UART_ERR_FLAGS_EN.
- With it:
  - Sticky tx_overflow is set by a dropped TX push.
  - Sticky rx_underflow is set by re_uart on empty.
  - Status reads (uart_sel 01/10) return the flags in bits [9:8] = {rx_underflow, tx_overflow}.
  - Both flags clear on ct_reset or reset.
- Without it: no flag registers, and bits [31:1] of status reads are 0.

Decomposition:
- Shared package mmio_pkg:
  - I/O address constants 0x80000000/04/08/0C/10/14/18.
  - uart_sel encodings (SEL_DATAOUT=00, SEL_DIN_READY=01, SEL_DOUT_VALID=10).
  - rd_src encodings.
- One sub-module: sync_fifo (parameterised width/depth; push/pop/full/empty/head), instantiated for TX (8b) and RX (8b).
- Counters and the read mux stay in the top module.

Test Plan:
- Reset then idle 5 cycles -> tx_valid=0, rx_ready=1; cycle read (rd_src=1, ct_sel=0) returns the count since reset; instr read returns 0.
- Push 0x41,0x42,0x43,0x44,0x45 with tx_ready=0 -> DataInReady reads 0 after the 4th push; 0x45 is dropped; with tx_ready=1, bytes leave in order 41..44 and tx_valid then falls.
- Core delivers 0x5A, 0xA5 -> DataOutValid reads 1; two re_uart DataOut reads return 0x5A then 0xA5; a third re_uart returns 0 with the FIFO still empty.
- Fill RX to 4 entries -> rx_ready=0; then simultaneous rx_valid and re_uart while rx_ready=1 at 3 entries -> count stays 3.
- Pulse instr_retire 7 times, then ct_reset -> the same-cycle read shows 7; the next read shows instr 0 and cycle 1 one cycle later; force cycle_count to 0xFFFFFFFF -> next value is 0.
- UART_ERR_FLAGS_EN: push to a full TX and pop an empty RX -> status reads show bits[9:8]=2'b11; after ct_reset, 2'b00.
